// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle RV32I control FSM
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB)
// and drives the datapath strobes. The opcode class and immediate format are
// captured in DECODE and held until the next DECODE; strobes are decoded from
// the current state and that registered class.
//
// Optional feature: define MC_CTRL_PERF_EN to add a 32-bit retired counter
// that counts cycles with PCWrite = 1 (wraps, resets to 0).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   imem_ready  instruction word valid (honoured only in FETCH)
//   instr       fetched instruction, held stable by the IR through DECODE
//   br_taken    branch-compare result (honoured only for a branch in EXEC)
//   dmem_ready  data access complete (honoured only in MEM)
//   imem_req    fetch request
//   IRWrite     latch instruction register
//   PCWrite     update PC
//   NPCOp       next-PC select: 0 PC+4, 1 branch, 2 JAL, 3 JALR
//   EXTOp       immediate format: 0 I, 1 S, 2 B, 3 J, 4 U
//   dmem_req    data access request
//   MemWrite    store strobe
//   RegWrite    register-file write strobe
//   WDSel       writeback source: 0 ALU, 1 memory, 2 PC+4
//   state       current FSM state
//   illegal     unsupported opcode seen (sticky until reset)
//   retired     (MC_CTRL_PERF_EN only) count of PCWrite cycles
// -----------------------------------------------------------------------------
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  NPCOp,
    output logic [5:0]  EXTOp,
    output logic        dmem_req,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  WDSel,
    output logic [2:0]  state,
    output logic        illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_ILLEGAL = 3'd5
    } state_t;

    // Opcode classes that behave differently after DECODE. OP, OP-IMM, LUI
    // and AUIPC all share the plain ALU path.
    typedef enum logic [2:0] {
        C_ALU    = 3'd0,
        C_LOAD   = 3'd1,
        C_STORE  = 3'd2,
        C_BRANCH = 3'd3,
        C_JAL    = 3'd4,
        C_JALR   = 3'd5
    } cls_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    state_t     state_q, state_d;
    cls_t       cls_q, dec_cls;
    logic [5:0] ext_op_q, dec_ext;
    logic       dec_legal;

    // Only the opcode steers control; the remaining fields belong to the
    // datapath (funct3 is handled by the ALU/LSU, not here).
    logic unused_instr;
    assign unused_instr = ^instr[31:7];

    // ---------------------------------------------------------------- decode
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        dec_cls   = C_ALU;
        dec_ext   = ext_op_q;   // R-type has no immediate: keep last format
        dec_legal = 1'b1;
        case (instr[6:0])
            OPC_LOAD:            begin dec_cls = C_LOAD;   dec_ext = 6'd0; end
            OPC_OPIMM:           begin dec_cls = C_ALU;    dec_ext = 6'd0; end
            OPC_JALR:            begin dec_cls = C_JALR;   dec_ext = 6'd0; end
            OPC_STORE:           begin dec_cls = C_STORE;  dec_ext = 6'd1; end
            OPC_BRANCH:          begin dec_cls = C_BRANCH; dec_ext = 6'd2; end
            OPC_JAL:             begin dec_cls = C_JAL;    dec_ext = 6'd3; end
            OPC_LUI, OPC_AUIPC:  begin dec_cls = C_ALU;    dec_ext = 6'd4; end
            OPC_OP:              dec_cls = C_ALU;
            default:             dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= S_FETCH;
            cls_q    <= C_ALU;
            ext_op_q <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q    <= dec_cls;
                ext_op_q <= dec_ext;
            end
        end
    end

    // ------------------------------------------------ next state and strobes
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        NPCOp    = 2'd0;
        dmem_req = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        WDSel    = 2'd0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                // Reset holds the FSM in FETCH; the fetch handshake must not
                // latch an instruction while that is happening.
                IRWrite  = imem_ready & ~rst;
                if (imem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = dec_legal ? S_EXEC : S_ILLEGAL;
            end
            S_EXEC: begin
                case (cls_q)
                    C_BRANCH: begin
                        PCWrite = 1'b1;
                        NPCOp   = br_taken ? 2'd1 : 2'd0;
                        state_d = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemWrite = (cls_q == C_STORE);
                if (dmem_ready) begin
                    if (cls_q == C_STORE) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                case (cls_q)
                    C_LOAD:  WDSel = 2'd1;
                    C_JAL:   begin WDSel = 2'd2; NPCOp = 2'd2; end
                    C_JALR:  begin WDSel = 2'd2; NPCOp = 2'd3; end
                    default: ;
                endcase
                state_d = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    assign state   = state_q;
    assign EXTOp   = ext_op_q;
    assign illegal = (state_q == S_ILLEGAL);

`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          retired_q <= 32'd0;
        else if (PCWrite) retired_q <= retired_q + 32'd1;  // wraps naturally
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl
//
// Each instruction is expanded by a reference model into the cycle-by-cycle
// trace the control rules imply (fetch waits, decode, exec, memory waits,
// writeback), together with the inputs to drive on each cycle. Inputs that the
// block must ignore in a given cycle are randomised.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_ready;
    logic [31:0] instr;
    logic        br_taken;
    logic        dmem_ready;
    logic        imem_req;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  NPCOp;
    logic [5:0]  EXTOp;
    logic        dmem_req;
    logic        MemWrite;
    logic        RegWrite;
    logic [1:0]  WDSel;
    logic [2:0]  state;
    logic        illegal;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] retired;
    logic [31:0] exp_retired;
`endif

    mc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .imem_ready (imem_ready),
        .instr      (instr),
        .br_taken   (br_taken),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .NPCOp      (NPCOp),
        .EXTOp      (EXTOp),
        .dmem_req   (dmem_req),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .WDSel      (WDSel),
        .state      (state),
        .illegal    (illegal)
`ifdef MC_CTRL_PERF_EN
        ,
        .retired    (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Everything observable in one cycle, packed for a single comparison.
    typedef struct packed {
        logic [2:0] st;
        logic       imq;
        logic       irw;
        logic       pcw;
        logic [1:0] npc;
        logic       dmq;
        logic       mw;
        logic       rw;
        logic [1:0] wd;
        logic [5:0] ext;
        logic       ill;
    } obs_t;

    typedef struct {
        logic imr;
        logic dmr;
        logic br;
        obs_t exp;
    } cyc_t;

    cyc_t       plan[$];
    logic [5:0] m_ext;      // model of the held immediate format
    int         n_checks;
    int         n_errors;
    int         cyc_no;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st  = state;    o.imq = imem_req; o.irw = IRWrite;  o.pcw = PCWrite;
        o.npc = NPCOp;    o.dmq = dmem_req; o.mw  = MemWrite; o.rw  = RegWrite;
        o.wd  = WDSel;    o.ext = EXTOp;    o.ill = illegal;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o     = '0;
        o.imq = 1'b1;
        return o;
    endfunction

    function automatic void push(input logic imr, input logic dmr, input logic br, input obs_t o);
        cyc_t c;
        c.imr = imr; c.dmr = dmr; c.br = br; c.exp = o;
        plan.push_back(c);
    endfunction

    // Expand one instruction into its expected trace.
    //   iw: FETCH wait cycles, dw: MEM wait cycles, ill_cycles: ILLEGAL cycles to observe
    task automatic plan_instr(input logic [6:0] op, input int iw, input int dw,
                              input logic br, input int ill_cycles);
        obs_t       o;
        logic [5:0] ext_new;
        bit         is_ld, is_st, is_br, is_jal, is_jalr, legal;
        is_ld   = (op == 7'h03);
        is_st   = (op == 7'h23);
        is_br   = (op == 7'h63);
        is_jal  = (op == 7'h6F);
        is_jalr = (op == 7'h67);
        legal   = 1'b1;
        ext_new = m_ext;
        case (op)
            7'h03, 7'h13, 7'h67: ext_new = 6'd0;
            7'h23:               ext_new = 6'd1;
            7'h63:               ext_new = 6'd2;
            7'h6F:               ext_new = 6'd3;
            7'h37, 7'h17:        ext_new = 6'd4;
            7'h33:               ext_new = m_ext;
            default:             legal   = 1'b0;
        endcase

        for (int i = 0; i <= iw; i++) begin
            o = '0; o.imq = 1'b1; o.irw = (i == iw); o.ext = m_ext;
            push(i == iw, rnd(), rnd(), o);
        end
        o = '0; o.st = 3'd1; o.ext = m_ext;
        push(rnd(), rnd(), rnd(), o);
        m_ext = ext_new;

        if (!legal) begin
            for (int i = 0; i < ill_cycles; i++) begin
                o = '0; o.st = 3'd5; o.ill = 1'b1; o.ext = m_ext;
                push(rnd(), rnd(), rnd(), o);
            end
            return;
        end

        o = '0; o.st = 3'd2; o.ext = m_ext;
        if (is_br) begin
            o.pcw = 1'b1;
            o.npc = br ? 2'd1 : 2'd0;
        end
        push(rnd(), rnd(), is_br ? br : rnd(), o);
        if (is_br) return;

        if (is_ld || is_st) begin
            for (int i = 0; i <= dw; i++) begin
                o = '0; o.st = 3'd3; o.dmq = 1'b1; o.mw = is_st; o.ext = m_ext;
                o.pcw = is_st && (i == dw);
                push(rnd(), i == dw, rnd(), o);
            end
            if (is_st) return;
        end

        o = '0; o.st = 3'd4; o.rw = 1'b1; o.pcw = 1'b1; o.ext = m_ext;
        o.wd  = is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
        o.npc = is_jal ? 2'd2 : is_jalr ? 2'd3 : 2'd0;
        push(rnd(), rnd(), rnd(), o);
    endtask

    // Called just after a rising edge; drives, samples, then advances one cycle.
    task automatic run_cycles(input int n);
        cyc_t c;
        for (int i = 0; i < n && plan.size() > 0; i++) begin
            c          = plan.pop_front();
            imem_ready = c.imr;
            dmem_ready = c.dmr;
            br_taken   = c.br;
            #1;
            check($sformatf("cycle%0d", cyc_no), 32'(observe()), 32'(c.exp));
`ifdef MC_CTRL_PERF_EN
            check($sformatf("retired%0d", cyc_no), retired, exp_retired);
            if (c.exp.pcw) exp_retired = exp_retired + 32'd1;
`endif
            cyc_no++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input logic [31:0] word, input int iw, input int dw, input logic br);
        instr = word;
        plan_instr(word[6:0], iw, dw, br, 0);
        run_cycles(plan.size());
    endtask

    // Asynchronous reset pulse starting mid-cycle; leaves the bench one
    // cycle later, just after a rising edge, with rst released.
    task automatic reset_pulse(input string tag);
        rst        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check({tag, "_async"}, 32'(observe()), 32'(reset_obs()));
        plan.delete();
        m_ext = 6'd0;
        @(posedge clk);
        #1;
        check({tag, "_held"}, 32'(observe()), 32'(reset_obs()));
`ifdef MC_CTRL_PERF_EN
        exp_retired = 32'd0;
        check({tag, "_retired"}, retired, exp_retired);
`endif
        rst = 1'b0;
    endtask

    logic [6:0] legal_ops [9];
    logic [31:0] r;

    initial begin
        legal_ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
        n_checks   = 0;
        n_errors   = 0;
        cyc_no     = 0;
        m_ext      = 6'd0;
        rst        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        br_taken   = 1'b1;
        instr      = 32'h0000_0013;
`ifdef MC_CTRL_PERF_EN
        exp_retired = 32'd0;
`endif

        // Reset state, with imem_ready high to show IRWrite stays low.
        #3;
        check("reset_async", 32'(observe()), 32'(reset_obs()));
        @(posedge clk);
        #1;
        check("reset_held", 32'(observe()), 32'(reset_obs()));
        rst = 1'b0;

        // Directed instructions.
        do_instr(32'h0050_0093, 0, 0, 1'b0);   // ADDI
        do_instr(32'h0011_2223, 0, 3, 1'b0);   // SW, dmem_ready after 3 waits
        do_instr(32'h0000_0463, 0, 0, 1'b1);   // BEQ taken
        do_instr(32'h0000_0463, 0, 0, 1'b0);   // BEQ not taken
        do_instr(32'h0080_00EF, 0, 0, 1'b0);   // JAL
        do_instr(32'h0000_0033, 2, 0, 1'b0);   // OP keeps EXTOp, fetch waits

        // Randomised instruction stream.
        for (int k = 0; k < 60; k++) begin
            r = $urandom();
            do_instr({r[31:7], legal_ops[$urandom_range(0, 8)]},
                     $urandom_range(0, 2), $urandom_range(0, 3), rnd());
        end

        // Reset during a load's MEM wait aborts it.
        r     = $urandom();
        instr = {r[31:7], 7'h03};
        plan_instr(7'h03, 0, 6, 1'b0, 0);
        run_cycles(5);                        // FETCH, DECODE, EXEC, 2 MEM waits
        check("abort_in_mem", 32'(state), 32'd3);
        reset_pulse("abort");

`ifdef MC_CTRL_PERF_EN
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_retired = 32'hFFFF_FFFF;
        check("retired_preset", retired, exp_retired);
        do_instr(32'h0050_0093, 0, 0, 1'b0);  // ADDI retires once -> wraps
        check("retired_wrap", retired, 32'd0);
`endif

        do_instr(32'h0050_0093, 0, 0, 1'b0);  // recovery after abort

        // Unsupported opcode sticks in ILLEGAL until reset.
        instr = 32'h0000_007F;
        plan_instr(7'h7F, 0, 0, 1'b0, 10);
        run_cycles(plan.size());
        check("illegal_sticky", 32'(illegal), 32'd1);
        reset_pulse("illegal_clear");
        do_instr(32'h0080_00EF, 1, 0, 1'b0);  // recovery: JAL

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
